// File: rtl/alu_add_and_cmp_pkg.sv
// Shared encodings for the add/and/compare ALU: opcodes, condition codes
// and bit positions inside the {N,Z,C,V} flag register.
package alu_add_and_cmp_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_CMP  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CC_AL = 4'h0,  // always
    CC_EQ = 4'h1,  // Z
    CC_GT = 4'h2,  // !Z & (N == V)
    CC_LT = 4'h3,  // N != V
    CC_GE = 4'h4,  // N == V
    CC_LE = 4'h5,  // Z | (N != V)
    CC_HI = 4'h6,  // C & !Z
    CC_LO = 4'h7,  // !C
    CC_HS = 4'h8   // C
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_add_and_cmp_cond.sv
// Condition-code evaluation: decides from the current flag register whether
// a request executes. Codes above CC_HS never execute.
module alu_cond_eval
  import alu_add_and_cmp_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       exec
);

  logic n, z, c, v;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    exec = 1'b0;
    case (cond)
      CC_AL:   exec = 1'b1;
      CC_EQ:   exec = z;
      CC_GT:   exec = !z && (n == v);
      CC_LT:   exec = (n != v);
      CC_GE:   exec = (n == v);
      CC_LE:   exec = z || (n != v);
      CC_HI:   exec = c && !z;
      CC_LO:   exec = !c;
      CC_HS:   exec = c;
      default: exec = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_add_and_cmp.sv
// Single-cycle conditional ADD / AND / CMP unit with a registered result and
// {N,Z,C,V} flag register; every accepted request retires one cycle later.
module alu_add_and_cmp
  import alu_add_and_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [3:0]       cond,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             out_valid,
  output logic [3:0]       flags
);

  logic             exec;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] and_r;
  logic             add_ovf;
  logic             sub_ovf;

  logic [WIDTH-1:0] result_nxt;
  logic [3:0]       flags_nxt;
  logic             wr_en_nxt;

  alu_cond_eval u_cond (
    .flags (flags),
    .cond  (cond),
    .exec  (exec)
  );

  // The extra top bit of diff is the borrow; C for compare is its inverse.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign and_r   = a & b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result_nxt = result;
    flags_nxt  = flags;
    wr_en_nxt  = 1'b0;
    if (in_valid && exec) begin
      case (op)
        OP_ADD: begin
          result_nxt = sum[WIDTH-1:0];
          wr_en_nxt  = 1'b1;
          if (s) begin
            flags_nxt[FLAG_N] = sum[WIDTH-1];
            flags_nxt[FLAG_Z] = (sum[WIDTH-1:0] == '0);
            flags_nxt[FLAG_C] = sum[WIDTH];
            flags_nxt[FLAG_V] = add_ovf;
          end
        end
        OP_AND: begin
          result_nxt = and_r;
          wr_en_nxt  = 1'b1;
          if (s) begin
            flags_nxt[FLAG_N] = and_r[WIDTH-1];
            flags_nxt[FLAG_Z] = (and_r == '0);
          end
        end
        OP_CMP: begin
          flags_nxt[FLAG_N] = diff[WIDTH-1];
          flags_nxt[FLAG_Z] = (diff[WIDTH-1:0] == '0);
          flags_nxt[FLAG_C] = !diff[WIDTH];
          flags_nxt[FLAG_V] = sub_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      flags     <= 4'b0000;
      wr_en     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      result    <= result_nxt;
      flags     <= flags_nxt;
      wr_en     <= wr_en_nxt;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_alu_add_and_cmp.sv
// Directed-vector bench for alu_add_and_cmp: a sequential table of requests
// with hand-computed results, plus reset-in-flight sequences.
module tb_alu_add_and_cmp;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  op;
  logic [3:0]  cond;
  logic        s;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        wr_en, out_valid;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_add_and_cmp #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .cond      (cond),
    .s         (s),
    .a         (a),
    .b         (b),
    .result    (result),
    .wr_en     (wr_en),
    .out_valid (out_valid),
    .flags     (flags)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        wr;
    logic        ov;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic iv, logic [1:0] o, logic [3:0] c, logic sf,
                              logic [31:0] va, logic [31:0] vb, logic [31:0] res,
                              logic [3:0] fl, logic wr, logic ov);
    vec_t t;
    t.iv = iv; t.op = o; t.cond = c; t.s = sf; t.a = va; t.b = vb;
    t.res = res; t.fl = fl; t.wr = wr; t.ov = ov;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [31:0] res, logic [3:0] fl, logic wr, logic ov);
    chk({tag, " result"},    result,           res);
    chk({tag, " flags"},     {28'd0, flags},   {28'd0, fl});
    chk({tag, " wr_en"},     {31'd0, wr_en},   {31'd0, wr});
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
  endtask

  // Drive one request for one edge, then sample 1 time unit after the edge.
  task automatic step(logic rst, logic iv, logic [1:0] o, logic [3:0] c, logic sf,
                      logic [31:0] va, logic [31:0] vb);
    @(negedge clk);
    reset = rst; in_valid = iv; op = o; cond = c; s = sf; a = va; b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in_valid, op, cond, s, a, b | result, flags, wr_en, out_valid
    vecs[0]  = mk(1, 2'b00, 4'h0, 1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1, 1);
    vecs[1]  = mk(0, 2'b00, 4'h0, 1, 32'h12345678, 32'h11111111, 32'h80000000, 4'b1001, 0, 0);
    vecs[2]  = mk(1, 2'b00, 4'h0, 1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1, 1);
    vecs[3]  = mk(1, 2'b00, 4'h0, 0, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0110, 1, 1);
    vecs[4]  = mk(1, 2'b10, 4'h0, 1, 32'h00000005, 32'h00000003, 32'h00000003, 4'b0010, 0, 1);
    vecs[5]  = mk(1, 2'b01, 4'h0, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0110, 1, 1);
    vecs[6]  = mk(1, 2'b01, 4'h0, 1, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 4'b1010, 1, 1);
    vecs[7]  = mk(1, 2'b10, 4'h0, 1, 32'h00000005, 32'h00000005, 32'h80000000, 4'b0110, 0, 1);
    vecs[8]  = mk(1, 2'b00, 4'h1, 0, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0110, 1, 1);
    vecs[9]  = mk(1, 2'b00, 4'h7, 0, 32'h0000000A, 32'h00000014, 32'h00000003, 4'b0110, 0, 1);
    vecs[10] = mk(1, 2'b10, 4'h0, 1, 32'h00000003, 32'h00000007, 32'h00000003, 4'b1000, 0, 1);
    vecs[11] = mk(1, 2'b00, 4'h4, 0, 32'h0000000A, 32'h00000014, 32'h00000003, 4'b1000, 0, 1);
    vecs[12] = mk(1, 2'b00, 4'h3, 0, 32'h0000000A, 32'h00000014, 32'h0000001E, 4'b1000, 1, 1);
    vecs[13] = mk(1, 2'b10, 4'h0, 0, 32'h80000000, 32'h00000001, 32'h0000001E, 4'b0011, 0, 1);
    vecs[14] = mk(1, 2'b11, 4'h0, 1, 32'h00000009, 32'h00000009, 32'h0000001E, 4'b0011, 0, 1);
    vecs[15] = mk(1, 2'b00, 4'h9, 1, 32'h00000001, 32'h00000001, 32'h0000001E, 4'b0011, 0, 1);
    vecs[16] = mk(1, 2'b00, 4'h2, 1, 32'h00000001, 32'h00000001, 32'h0000001E, 4'b0011, 0, 1);
    vecs[17] = mk(1, 2'b00, 4'h5, 1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 1, 1);
    vecs[18] = mk(1, 2'b00, 4'h8, 1, 32'h00000005, 32'h00000005, 32'h00000002, 4'b0000, 0, 1);
    vecs[19] = mk(1, 2'b00, 4'h6, 1, 32'h00000005, 32'h00000005, 32'h00000002, 4'b0000, 0, 1);

    reset = 1'b1; in_valid = 1'b0; op = 2'b00; cond = 4'h0; s = 1'b0; a = '0; b = '0;
    step(1, 1, 2'b00, 4'h0, 1, 32'h00000001, 32'h00000001);
    step(1, 0, 2'b00, 4'h0, 0, 32'h0, 32'h0);
    check_all("reset", 32'h0, 4'b0000, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(0, vecs[i].iv, vecs[i].op, vecs[i].cond, vecs[i].s, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].fl, vecs[i].wr, vecs[i].ov);
    end

    // Reset arriving together with a request must discard it.
    step(0, 1, 2'b00, 4'h0, 1, 32'hFFFFFFFF, 32'h00000001);
    check_all("pre_rst_a", 32'h0, 4'b0110, 1, 1);
    step(0, 1, 2'b00, 4'h0, 0, 32'h00000004, 32'h00000005);
    check_all("pre_rst_b", 32'h9, 4'b0110, 1, 1);
    step(1, 1, 2'b00, 4'h0, 1, 32'h00000001, 32'h00000001);
    check_all("rst_with_req", 32'h0, 4'b0000, 0, 0);

    // After reset the condition sees flags 0000, and s=0 leaves them clear.
    step(0, 1, 2'b00, 4'h0, 0, 32'hFFFFFFFF, 32'h00000001);
    check_all("post_rst_s0", 32'h0, 4'b0000, 1, 1);
    step(0, 1, 2'b00, 4'h1, 1, 32'h00000004, 32'h00000004);
    check_all("post_rst_eq", 32'h0, 4'b0000, 0, 1);
    step(0, 1, 2'b00, 4'h7, 0, 32'h00000004, 32'h00000004);
    check_all("post_rst_lo", 32'h8, 4'b0000, 1, 1);
    step(0, 0, 2'b00, 4'h0, 0, 32'h0, 32'h0);
    check_all("idle_end", 32'h8, 4'b0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_add_and_cmp.md
ALU_ADD_AND_CMP -- requirements
Module: alu_add_and_cmp

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; all requirements below use WIDTH=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request this cycle.
REQ-005 op  input  2  operation: 00 ADD, 01 AND, 10 CMP, 11 reserved.
REQ-006 cond  input  4  execution condition code (REQ-014).
REQ-007 s  input  1  flag-update enable for ADD/AND; ignored for CMP.
REQ-008 a  input  32  operand 1, two's complement.
REQ-009 b  input  32  operand 2, two's complement.
REQ-010 result  output  32  registered result of last executed ADD/AND.
REQ-011 wr_en  output  1  one-cycle pulse: result updated by an executed ADD/AND.
REQ-012 out_valid  output  1  one-cycle pulse: request accepted and retired (executed or skipped).
REQ-013 flags  output  4  flag register {N,Z,C,V} at bits [3:0] = N,Z,C,V (bit3 N, bit2 Z, bit1 C, bit0 V).

Function
REQ-014 Condition uses flags register value before the current edge: 0000 always; 0001 Z; 0010 !Z&(N==V); 0011 N!=V; 0100 N==V; 0101 Z|(N!=V); 0110 C&!Z; 0111 !C; 1000 C; 1001-1111 never.
REQ-015 Latency one cycle: request sampled at edge k; result/wr_en/out_valid/flags valid after edge k.
REQ-016 out_valid=1 for every in_valid request, including skipped and op=11.
REQ-017 ADD executed: result=a+b mod 2^32; wr_en=1; if s=1: N=result[31], Z=(result==0), C=carry out of bit 31, V=(a[31]==b[31])&(result[31]!=a[31]); if s=0 flags unchanged.
REQ-018 AND executed: result=a&b; wr_en=1; if s=1: N=result[31], Z=(result==0), C and V unchanged; if s=0 flags unchanged.
REQ-019 CMP executed: d=a-b computed internally; result unchanged; wr_en=0; flags always written: N=d[31], Z=(d==0), C=1 iff a>=b unsigned (no borrow), V=(a[31]!=b[31])&(d[31]!=a[31]).
REQ-020 Condition false, or op=11: result and flags unchanged, wr_en=0.
REQ-021 No request (in_valid=0): wr_en=0, out_valid=0, result and flags hold.
REQ-022 Back-to-back requests accepted every cycle; no stall; flags from request k govern condition of request k+1.
REQ-023 Arithmetic wraps modulo 2^32; no saturation; carry/overflow only reported via flags.

Reset
REQ-024 When reset=1 at an edge: result=0, flags=0000, wr_en=0, out_valid=0; any in_valid that cycle is discarded.
REQ-025 Reset mid-stream: request sampled with reset=1 never produces out_valid; first request after reset evaluates condition against flags=0000.

Structure
REQ-026 Shared package holds op encodings, condition-code encodings, flag bit indices (N=3, Z=2, C=1, V=0).
REQ-027 One sub-module natural: alu_cond_eval (combinational, flags+cond -> execute bit); datapath and registers stay in top.

Verification
REQ-028 ADD a=0x7FFFFFFF b=0x00000001 s=1 cond=0000 -> result 0x80000000, flags 1001, wr_en=1, out_valid=1 next cycle.
REQ-029 ADD a=0xFFFFFFFF b=0x00000001 s=1 -> result 0x00000000, flags 0110; repeat with s=0 from flags 0000 -> flags stay 0000.
REQ-030 With flags 0010, AND a=0xF0F0F0F0 b=0x0F0F0F0F s=1 -> result 0x00000000, flags 0110 (C preserved).
REQ-031 CMP a=5 b=5 -> flags 0110, wr_en=0, result unchanged; next ADD a=1 b=2 cond=0001 -> result 3, wr_en=1; next ADD cond=0111 -> skipped, wr_en=0, out_valid=1.
REQ-032 CMP a=3 b=7 -> flags 1000; next ADD cond=0100 skipped, following ADD cond=0011 executes; CMP a=0x80000000 b=1 -> flags 0011.
REQ-033 Assert reset in same cycle as in_valid ADD a=1 b=1 -> after edge result 0, flags 0000, wr_en=0, out_valid=0; reserved op=11 -> out_valid=1, wr_en=0, state unchanged.
